// File: rtl/mul_ctrl_if.sv
// Bundle between the execute stage, the multiply sequencing controller and the shared
// unsigned multiplier: request/response handshakes plus the multiplier start/busy pair.
interface mul_ctrl_if #(
  parameter int WIDTH = 32
);
  logic               req_valid;
  logic               req_ready;
  logic [1:0]         req_op;
  logic [WIDTH-1:0]   req_rs1;
  logic [WIDTH-1:0]   req_rs2;
  logic               resp_valid;
  logic               resp_ready;
  logic [WIDTH-1:0]   resp_data;
  logic               mul_start;
  logic [WIDTH-1:0]   mul_multiplier;
  logic [WIDTH-1:0]   mul_multiplicand;
  logic               mul_busy;
  logic [2*WIDTH-1:0] mul_product;

  // The controller side
  modport slave (
    input  req_valid, req_op, req_rs1, req_rs2, resp_ready, mul_busy, mul_product,
    output req_ready, resp_valid, resp_data, mul_start, mul_multiplier, mul_multiplicand
  );

  // The execute stage and multiplier side
  modport master (
    output req_valid, req_op, req_rs1, req_rs2, resp_ready, mul_busy, mul_product,
    input  req_ready, resp_valid, resp_data, mul_start, mul_multiplier, mul_multiplicand
  );
endinterface

// File: rtl/mul_ctrl.sv
// RV32M multiply sequencer: turns signed requests into magnitude products on the shared
// unsigned multiplier, applies sign fix-up and reuses the last magnitude product when it can.
module mul_ctrl #(
  parameter int WIDTH    = 32,
  parameter bit CACHE_EN = 1'b1
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     flush,
  mul_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, START, WAIT_HI, WAIT_LO, FIX, RESP, DRAIN} state_t;

  state_t               state;
  state_t               state_next;
  logic [1:0]           op_q;
  logic                 neg_q;
  logic [WIDTH-1:0]     mag_a_q;
  logic [WIDTH-1:0]     mag_b_q;
  logic [WIDTH-1:0]     cache_a;
  logic [WIDTH-1:0]     cache_b;
  logic [2*WIDTH-1:0]   cache_prod;
  logic                 cache_valid;
  logic [WIDTH-1:0]     resp_data_q;

  logic                 a_neg;
  logic                 b_neg;
  logic [WIDTH-1:0]     mag_a;
  logic [WIDTH-1:0]     mag_b;
  logic                 accept;
  logic                 cache_hit;
  logic                 capture;
  logic [2*WIDTH-1:0]   fixed_prod;

  // MULH/MULHSU treat A as signed, only MULH treats B as signed; MUL and MULHU are unsigned
  always_comb begin
    a_neg      = ((bus.req_op == 2'b01) || (bus.req_op == 2'b10)) && bus.req_rs1[WIDTH-1];
    b_neg      = (bus.req_op == 2'b01) && bus.req_rs2[WIDTH-1];
    mag_a      = a_neg ? ({WIDTH{1'b0}} - bus.req_rs1) : bus.req_rs1;
    mag_b      = b_neg ? ({WIDTH{1'b0}} - bus.req_rs2) : bus.req_rs2;
    accept     = bus.req_valid && (state == IDLE) && !flush;
    cache_hit  = CACHE_EN && cache_valid && (mag_a == cache_a) && (mag_b == cache_b);
    capture    = (state == WAIT_LO) && !bus.mul_busy && !flush;
    fixed_prod = neg_q ? ({(2*WIDTH){1'b0}} - cache_prod) : cache_prod;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = cache_hit ? FIX : START;
      START:   state_next = flush ? DRAIN : WAIT_HI;
      WAIT_HI: if (flush) state_next = DRAIN;
               else if (bus.mul_busy) state_next = WAIT_LO;
      WAIT_LO: if (flush) state_next = DRAIN;
               else if (!bus.mul_busy) state_next = FIX;
      FIX:     state_next = flush ? IDLE : RESP;
      RESP:    if (flush || bus.resp_ready) state_next = IDLE;
      DRAIN:   if (!bus.mul_busy) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Every finished multiply refills the product register, so a miss and a hit share the FIX path
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q        <= 2'b00;
      neg_q       <= 1'b0;
      mag_a_q     <= '0;
      mag_b_q     <= '0;
      cache_a     <= '0;
      cache_b     <= '0;
      cache_prod  <= '0;
      cache_valid <= 1'b0;
      resp_data_q <= '0;
    end else begin
      if (accept) begin
        op_q    <= bus.req_op;
        neg_q   <= a_neg ^ b_neg;
        mag_a_q <= mag_a;
        mag_b_q <= mag_b;
      end
      if (capture) begin
        cache_prod  <= bus.mul_product;
        cache_a     <= mag_a_q;
        cache_b     <= mag_b_q;
        cache_valid <= CACHE_EN;
      end
      if (state == FIX) begin
        resp_data_q <= (op_q == 2'b00) ? fixed_prod[WIDTH-1:0] : fixed_prod[2*WIDTH-1:WIDTH];
      end
    end
  end

  assign bus.req_ready        = (state == IDLE);
  assign bus.resp_valid       = (state == RESP);
  assign bus.mul_start        = (state == START);
  assign bus.resp_data        = resp_data_q;
  assign bus.mul_multiplier   = mag_a_q;
  assign bus.mul_multiplicand = mag_b_q;

endmodule

// File: tb/tb_mul_ctrl.sv
// Directed bench for mul_ctrl against an ideal 32-cycle multiplier: vector table for results,
// cache hits and latency, plus hand sequences for flush, response stall and async reset.
module tb_mul_ctrl;

  localparam int WIDTH = 32;
  // Edges after the accept edge until resp_valid is seen: hit goes FIX->RESP, a miss adds
  // START, WAIT_HI, 32 busy cycles observed in WAIT_LO and FIX
  localparam int HIT_LAT  = 1;
  localparam int MISS_LAT = 35;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  int n_checks  = 0;
  int n_fail    = 0;
  int start_cnt = 0;
  int busy_cnt  = 0;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;

  mul_ctrl_if #(.WIDTH(WIDTH)) bus ();

  mul_ctrl #(.WIDTH(WIDTH), .CACHE_EN(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Ideal multiplier: busy from the cycle after start for 32 cycles, garbage product until done
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.mul_busy    <= 1'b0;
      bus.mul_product <= '0;
      busy_cnt        <= 0;
    end else if (bus.mul_start) begin
      bus.mul_busy    <= 1'b1;
      bus.mul_product <= 64'hDEAD_BEEF_DEAD_BEEF;
      busy_cnt        <= 32;
      opa             <= bus.mul_multiplier;
      opb             <= bus.mul_multiplicand;
      start_cnt       <= start_cnt + 1;
    end else if (busy_cnt == 1) begin
      bus.mul_busy    <= 1'b0;
      bus.mul_product <= (2*WIDTH)'(opa) * (2*WIDTH)'(opb);
      busy_cnt        <= 0;
    end else if (busy_cnt > 1) begin
      busy_cnt <= busy_cnt - 1;
    end
  end

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] exp_data;
    bit          exp_hit;
  } vec_t;

  vec_t vecs [14];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 100 && !bus.req_ready; i++) next_cycle();
  endtask

  task automatic send_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    wait_ready();
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_rs1   = a;
    bus.req_rs2   = b;
    next_cycle();
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_resp(output int lat);
    lat = 0;
    while (!bus.resp_valid && lat < 200) begin
      next_cycle();
      lat++;
    end
  endtask

  task automatic apply_stimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] data, output int lat, output int starts);
    int s0;
    s0 = start_cnt;
    send_req(op, a, b);
    wait_resp(lat);
    data   = bus.resp_data;
    starts = start_cnt - s0;
    bus.resp_ready = 1'b1;
    next_cycle();
    bus.resp_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] data;
    int lat;
    int starts;
    int s0;
    bit bad_ready;
    bit bad_valid;
    bit busy_low;

    vecs[0]  = '{"mulhu_max",      2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0};
    vecs[1]  = '{"mul_max_hit",    2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b1};
    vecs[2]  = '{"mulh_minint",    2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0};
    vecs[3]  = '{"mulhsu_m1x2",    2'b10, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 1'b0};
    vecs[4]  = '{"mul_m3x7",       2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFEB, 1'b0};
    vecs[5]  = '{"mulh_m3x7",      2'b01, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 1'b0};
    vecs[6]  = '{"mulhsu_m3x7",    2'b10, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 1'b1};
    vecs[7]  = '{"mul_3x7_hit",    2'b00, 32'h00000003, 32'h00000007, 32'h00000015, 1'b1};
    vecs[8]  = '{"mulhu_3x7_hit",  2'b11, 32'h00000003, 32'h00000007, 32'h00000000, 1'b1};
    vecs[9]  = '{"mulh_min_max",   2'b01, 32'h80000000, 32'h7FFFFFFF, 32'hC0000000, 1'b0};
    vecs[10] = '{"mulhsu_min_max", 2'b10, 32'h80000000, 32'h7FFFFFFF, 32'hC0000000, 1'b1};
    vecs[11] = '{"mulhu_zero",     2'b11, 32'h00000000, 32'h00000005, 32'h00000000, 1'b0};
    vecs[12] = '{"mul_7xm3",       2'b00, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0};
    vecs[13] = '{"mulh_7xm3",      2'b01, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0};

    bus.req_valid  = 1'b0;
    bus.req_op     = 2'b00;
    bus.req_rs1    = '0;
    bus.req_rs2    = '0;
    bus.resp_ready = 1'b0;

    #12;
    check_output("rst_req_ready",  32'(bus.req_ready), 32'd1);
    check_output("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check_output("rst_mul_start",  32'(bus.mul_start), 32'd0);
    check_output("rst_resp_data",  bus.resp_data, 32'd0);
    check_output("rst_multiplier", bus.mul_multiplier, 32'd0);
    rst_n = 1'b1;
    next_cycle();

    for (int i = 0; i < 14; i++) begin
      apply_stimulus(vecs[i].op, vecs[i].rs1, vecs[i].rs2, data, lat, starts);
      check_output({vecs[i].name, "_data"}, data, vecs[i].exp_data);
      check_output({vecs[i].name, "_starts"}, 32'(starts), vecs[i].exp_hit ? 32'd0 : 32'd1);
      check_output({vecs[i].name, "_latency"}, 32'(lat), vecs[i].exp_hit ? 32'(HIT_LAT) : 32'(MISS_LAT));
      check_output({vecs[i].name, "_ready_after"}, 32'(bus.req_ready), 32'd1);
    end

    // Flush with a request pending in IDLE: request must be dropped
    s0 = start_cnt;
    bus.req_valid = 1'b1;
    bus.req_op    = 2'b11;
    bus.req_rs1   = 32'd11;
    bus.req_rs2   = 32'd13;
    flush         = 1'b1;
    next_cycle();
    bus.req_valid = 1'b0;
    flush         = 1'b0;
    check_output("idle_flush_ready", 32'(bus.req_ready), 32'd1);
    next_cycle();
    check_output("idle_flush_starts", 32'(start_cnt - s0), 32'd0);

    // Flush while waiting on the multiplier
    send_req(2'b11, 32'd5, 32'd5);
    for (int i = 0; i < 10; i++) next_cycle();
    flush = 1'b1;
    next_cycle();
    flush = 1'b0;
    bad_ready = 1'b0;
    bad_valid = 1'b0;
    busy_low  = 1'b0;
    for (int i = 0; i < 60 && !busy_low; i++) begin
      if (!bus.mul_busy) busy_low = 1'b1;
      bad_ready |= bus.req_ready;
      bad_valid |= bus.resp_valid;
      if (!busy_low) next_cycle();
    end
    check_output("drain_busy_falls", 32'(busy_low), 32'd1);
    check_output("drain_ready_low", 32'(bad_ready), 32'd0);
    next_cycle();
    bad_valid |= bus.resp_valid;
    check_output("drain_no_resp", 32'(bad_valid), 32'd0);
    check_output("drain_ready_back", 32'(bus.req_ready), 32'd1);
    apply_stimulus(2'b00, 32'd6, 32'd7, data, lat, starts);
    check_output("post_flush_data", data, 32'd42);
    check_output("post_flush_starts", 32'(starts), 32'd1);

    // Consumer stalls the response for 5 cycles
    send_req(2'b11, 32'h80000000, 32'h00000004);
    wait_resp(lat);
    check_output("stall_resp_seen", 32'(bus.resp_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      check_output("stall_resp_valid", 32'(bus.resp_valid), 32'd1);
      check_output("stall_resp_data", bus.resp_data, 32'd2);
      check_output("stall_req_ready", 32'(bus.req_ready), 32'd0);
      next_cycle();
    end
    bus.resp_ready = 1'b1;
    next_cycle();
    bus.resp_ready = 1'b0;
    check_output("stall_released", 32'(bus.resp_valid), 32'd0);

    // Async reset in WAIT_LO must also invalidate the cached 9x9 product
    apply_stimulus(2'b00, 32'd9, 32'd9, data, lat, starts);
    check_output("pre_reset_data", data, 32'd81);
    send_req(2'b00, 32'd3, 32'd3);
    for (int i = 0; i < 10; i++) next_cycle();
    #2;
    rst_n = 1'b0;
    #1;
    check_output("async_req_ready",  32'(bus.req_ready), 32'd1);
    check_output("async_resp_valid", 32'(bus.resp_valid), 32'd0);
    check_output("async_mul_start",  32'(bus.mul_start), 32'd0);
    check_output("async_resp_data",  bus.resp_data, 32'd0);
    check_output("async_multiplier", bus.mul_multiplier, 32'd0);
    check_output("async_multiplicand", bus.mul_multiplicand, 32'd0);
    #1;
    rst_n = 1'b1;
    next_cycle();
    apply_stimulus(2'b00, 32'd9, 32'd9, data, lat, starts);
    check_output("post_reset_data", data, 32'd81);
    check_output("post_reset_starts", 32'(starts), 32'd1);
    check_output("post_reset_latency", 32'(lat), 32'(MISS_LAT));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
